// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the CPU-side FSM/datapath.
// Provides the responder state encoding, word geometry constants, default
// bus widths and an alignment helper.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam logic [BYTE_OFF_W-1:0] ALIGN_MASK = BYTE_OFF_W'(WORD_BYTES - 1);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // True when the byte offset is not word aligned.
  function automatic logic is_misaligned(input logic [BYTE_OFF_W-1:0] byte_off);
    return |(byte_off & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word array (read-first).
// Ports: clk; we (write enable); index (word index); wdata (write data);
// rdata (registered read data of mem[index], one cycle after index).
// Contents are not reset, so this can map directly onto block RAM.
module mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request over a valid/ready
// handshake, holds it for WAIT_STATES cycles, accesses the internal array,
// then returns the response over a second valid/ready handshake.
// Ports: clk, rst_n (async active-low);
//   req_valid/req_ready/req_we/req_addr/req_wdata - request channel;
//   resp_valid/resp_ready/resp_rdata/resp_err      - response channel;
//   busy - high whenever the FSM is not IDLE.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WIDX_W = ADDR_W - BYTE_OFF_W;
  localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

  // The wait counter is 4 bits wide.
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_responder: WAIT_STATES must be in 0..15");
  end

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               err_q;
  logic               latch_en;
  logic               arr_we;
  logic               set_resp;
  logic               clr_resp;
  logic               acc_err;
  logic [DATA_W-1:0]  arr_rdata;
  logic [WIDX_W-1:0]  word_idx;

  // Address checks on the latched request.
  assign word_idx = addr_q[ADDR_W-1:BYTE_OFF_W];
  assign acc_err  = is_misaligned(addr_q[BYTE_OFF_W-1:0])
                  | ({1'b0, word_idx} >= (WIDX_W + 1)'(DEPTH));

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Next-state and control decode.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    latch_en = 1'b0;
    arr_we   = 1'b0;
    set_resp = 1'b0;
    clr_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          latch_en = 1'b1;
          cnt_d    = WS_CNT;
          state_d  = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Errored writes are blocked from the array.
        arr_we  = we_q & ~acc_err;
        state_d = RESP;
      end
      RESP: begin
        // First RESP cycle captures the array's registered read data.
        if (!resp_valid) begin
          set_resp = 1'b1;
        end else if (resp_ready) begin
          clr_resp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      if (latch_en) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        err_q <= acc_err;
      end
      if (set_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= err_q;
        resp_rdata <= (we_q || err_q) ? '0 : arr_rdata;
      end else if (clr_resp) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
